mem_write_a_pp: RTL and testbench
=================================

# mem_write_a_pp

Write-side address and bank-enable generator for matrix A operand storage in front of the N1-row systolic array. It accepts a beat stream of A elements under a valid/ready handshake and steers each element to one of N1 row banks at a per-bank address. It adds two capabilities to a plain write counter: ping-pong double buffering, so the array can read one tile while the next is loaded, and a transposed (column-major) input mode. Per-job configuration is latched on a start pulse, and completion is reported with a done pulse.

## Interface
Parameters:
- N1, 4: systolic rows; number of A banks.
- MATRIXSIZE_W, 16: width of matrix dimension fields.
- ADDR_W, 12: per-bank write address width.
- BUF_STRIDE, 2048: words per ping-pong half. Buffer 0 base = 0; buffer 1 base = BUF_STRIDE. Requires 2*BUF_STRIDE <= 2^ADDR_W.

Ports:
- clk  in  1  clock; the block uses this single clock only.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; ignored unless state is IDLE.
- cfg_M2  in  MATRIXSIZE_W  columns of A (K dimension).
- cfg_M1dN1  in  MATRIXSIZE_W  rows of A divided by N1 (number of phases).
- cfg_transpose  in  1  0 = row-major input, 1 = column-major input.
- valid_A  in  1  input beat valid.
- ready_A  out  1  input beat accepted when valid_A & ready_A.
- buf_release  in  2  one-hot per buffer; the consumer frees that buffer.
- wr_addr_A  out  ADDR_W  bank write address.
- activate_A  out  N1  one-hot bank write enable; all zero means no write.
- wr_buf_sel  out  1  buffer targeted by the current write.
- buf_full  out  2  per-buffer "holds a complete tile" flag.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle job completion pulse.
- cfg_err  out  1  one-cycle pulse: job rejected because the tile does not fit.

## Operation
- States:
  - IDLE: ready_A = 0.
  - WAIT_BUF: ready_A = 0.
  - WRITE: ready_A = 1.
  - FINISH: one cycle; ready_A = 0.
- IDLE + start:
  - Latch the cfg_* fields.
  - Compute tile = cfg_M2*cfg_M1dN1*N1 words in total, i.e. cfg_M2*cfg_M1dN1 words per bank.
  - If cfg_M2 == 0 or cfg_M1dN1 == 0: go to FINISH; no writes; buffer state unchanged.
  - Else if cfg_M2*cfg_M1dN1 > BUF_STRIDE: pulse cfg_err, go to FINISH; no writes.
  - Else go to WAIT_BUF.
- WAIT_BUF: move to WRITE when buf_full[ptr] == 0, where ptr is the internal fill pointer. The move happens in the same cycle that condition is observed, including a release arriving in that cycle.
- WRITE, per accepted beat:
  - Counters: col (0..M2-1), sys_row (0..N1-1), phase (0..M1dN1-1).
  - Mode 0 nesting, innermost first: col, then sys_row, then phase.
  - Mode 1 nesting, innermost first: sys_row, then phase, then col.
  - Address = ptr*BUF_STRIDE + phase*M2 + col. Keep a running offset (offset += M2 per phase step) rather than a multiplier; compute in MATRIXSIZE_W+1 bits and truncate to ADDR_W.
  - Bank = onehot(sys_row).
- Last beat (all counters at maximum): set buf_full[ptr], toggle ptr, go to FINISH.
- FINISH: pulse done, go to IDLE.
- buf_release:
  - Clears the addressed buf_full bit(s).
  - A release of a bit that is not full is ignored.
  - Set and release of the same bit in the same cycle: set wins.
- valid_A while ready_A = 0: beat is not consumed and causes no write.
- start outside IDLE: ignored; latched config is unchanged.
- rst mid-job: the partial tile is abandoned, and every register returns to its reset value.

## Timing
- Reset values:
  - wr_addr_A = 0, activate_A = 0, wr_buf_sel = 0.
  - buf_full = 2'b00, busy = 0, done = 0, cfg_err = 0, ready_A = 0.
  - ptr = 0, state = IDLE.
- Write outputs are registered: wr_addr_A, activate_A and wr_buf_sel appear 1 cycle after the accepting edge. activate_A is zero in every cycle with no accept in the previous cycle.
- start to ready_A high: 2 cycles when the target buffer is free (IDLE to WAIT_BUF to WRITE).
- ready_A drops in the cycle after the final accept. buf_full, activate_A and done for the final beat are updated together, 1 cycle after the final accept.
- Sustained throughput: 1 beat per cycle.
- done after a zero-size job or a cfg_err job: 2 cycles after start.
- Back-to-back jobs: the next start is accepted the cycle after done.

## Test plan
- Mode 0, N1=4, M2=3, M1dN1=2, buf 0 free, 24 continuous beats -> addresses 0,1,2 on bank 0001; 0,1,2 on 0010; 0,1,2 on 0100; 0,1,2 on 1000; then 3,4,5 on each bank in turn. done and buf_full = 01 one cycle after beat 24.
- Mode 1, same sizes -> first beats: (0, 0001), (0, 0010), (0, 0100), (0, 1000), (3, 0001), ..., (3, 1000), then (1, 0001), and so on.
- Second job with buf_full = 01 -> all addresses offset by 2048, wr_buf_sel = 1, buf_full = 11. A third start stalls in WAIT_BUF with ready_A = 0 until buf_release = 01, then writes at base 0.
- Random valid_A gaps in mode 0 -> the address/bank sequence is identical to the gap-free run; activate_A = 0 in every cycle following a non-accept.
- cfg_M2=100, cfg_M1dN1=21 (2100 > 2048) -> cfg_err and done pulses, no activate_A, buf_full unchanged. cfg_M2 = 0 -> done only.
- rst asserted at beat 10 of a job -> next cycle all outputs are at reset values. A new job then starts at address 0 on buffer 0.

Source files
------------

// File: rtl/mem_write_a_pp.sv
// mem_write_a_pp: write-side address/bank-enable generator for the A operand banks,
// with ping-pong double buffering and an optional column-major input order.
`default_nettype none
`timescale 1ns/1ps

module mem_write_a_pp #(
   parameter int N1           = 4,
   parameter int MATRIXSIZE_W = 16,
   parameter int ADDR_W       = 12,
   parameter int BUF_STRIDE   = 2048
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MATRIXSIZE_W-1:0] cfg_M2,
   input  logic [MATRIXSIZE_W-1:0] cfg_M1dN1,
   input  logic                    cfg_transpose,
   input  logic                    valid_A,
   output logic                    ready_A,
   input  logic [1:0]              buf_release,
   output logic [ADDR_W-1:0]       wr_addr_A,
   output logic [N1-1:0]           activate_A,
   output logic                    wr_buf_sel,
   output logic [1:0]              buf_full,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err
);

   localparam int ROW_W  = (N1 > 1) ? $clog2(N1) : 1;
   localparam int PROD_W = 2 * MATRIXSIZE_W;

   typedef enum logic [1:0] {IDLE, WAIT_BUF, WRITE, FINISH} state_t;

   state_t                  state;
   logic [MATRIXSIZE_W-1:0] m2;
   logic [MATRIXSIZE_W-1:0] m1dn1;
   logic                    transpose;
   logic                    ptr;
   logic [MATRIXSIZE_W-1:0] col;
   logic [MATRIXSIZE_W-1:0] phase;
   logic [ROW_W-1:0]        sys_row;
   logic [MATRIXSIZE_W:0]   offset;

   logic [PROD_W-1:0]       tile_words;
   logic                    col_last;
   logic                    row_last;
   logic                    phase_last;
   logic                    accept;
   logic                    last_beat;
   logic [MATRIXSIZE_W:0]   bank_addr;
   logic [ADDR_W-1:0]       base;
   logic [1:0]              buf_set;

   assign tile_words = PROD_W'(cfg_M2) * PROD_W'(cfg_M1dN1);
   assign col_last   = (col == m2 - 1'b1);
   assign row_last   = (sys_row == ROW_W'(N1 - 1));
   assign phase_last = (phase == m1dn1 - 1'b1);
   assign last_beat  = col_last & row_last & phase_last;
   assign ready_A    = (state == WRITE);
   assign busy       = (state != IDLE);
   assign accept     = valid_A & ready_A;
   assign bank_addr  = offset + {1'b0, col};
   assign base       = ptr ? ADDR_W'(BUF_STRIDE) : '0;
   assign buf_set    = (accept && last_beat) ? (ptr ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         m2         <= '0;
         m1dn1      <= '0;
         transpose  <= 1'b0;
         ptr        <= 1'b0;
         col        <= '0;
         phase      <= '0;
         sys_row    <= '0;
         offset     <= '0;
         wr_addr_A  <= '0;
         activate_A <= '0;
         wr_buf_sel <= 1'b0;
         buf_full   <= 2'b00;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         activate_A <= '0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         // A tile completing in the same cycle as a release of that buffer stays full.
         buf_full   <= (buf_full & ~buf_release) | buf_set;

         if (accept) begin
            wr_addr_A  <= base + ADDR_W'(bank_addr);
            activate_A <= N1'(1) << sys_row;
            wr_buf_sel <= ptr;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  m2        <= cfg_M2;
                  m1dn1     <= cfg_M1dN1;
                  transpose <= cfg_transpose;
                  col       <= '0;
                  phase     <= '0;
                  sys_row   <= '0;
                  offset    <= '0;
                  if (cfg_M2 == '0 || cfg_M1dN1 == '0) begin
                     state <= FINISH;
                  end else if (tile_words > PROD_W'(BUF_STRIDE)) begin
                     cfg_err <= 1'b1;
                     state   <= FINISH;
                  end else begin
                     state <= WAIT_BUF;
                  end
               end
            end
            WAIT_BUF: begin
               if (!buf_full[ptr] || buf_release[ptr]) state <= WRITE;
            end
            WRITE: begin
               if (accept) begin
                  if (last_beat) begin
                     ptr   <= ~ptr;
                     done  <= 1'b1;
                     state <= FINISH;
                  end else if (!transpose) begin
                     if (!col_last) begin
                        col <= col + 1'b1;
                     end else begin
                        col <= '0;
                        if (!row_last) begin
                           sys_row <= sys_row + 1'b1;
                        end else begin
                           sys_row <= '0;
                           phase   <= phase + 1'b1;
                           offset  <= offset + {1'b0, m2};
                        end
                     end
                  end else begin
                     if (!row_last) begin
                        sys_row <= sys_row + 1'b1;
                     end else begin
                        sys_row <= '0;
                        if (!phase_last) begin
                           phase  <= phase + 1'b1;
                           offset <= offset + {1'b0, m2};
                        end else begin
                           phase  <= '0;
                           offset <= '0;
                           col    <= col + 1'b1;
                        end
                     end
                  end
               end
            end
            FINISH: begin
               // done was already raised with the final beat; otherwise (empty or
               // rejected job) it is raised here, two cycles after start.
               done  <= ~done;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_a_pp.sv
// Scoreboard bench for mem_write_a_pp: expected writes are queued by the stimulus
// and checked by an independent monitor whenever activate_A is non-zero.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_write_a_pp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cfg_M2 = '0;
   logic [15:0] cfg_M1dN1 = '0;
   logic        cfg_transpose = 1'b0;
   logic        valid_A = 1'b0;
   logic        ready_A;
   logic [1:0]  buf_release = 2'b00;
   logic [11:0] wr_addr_A;
   logic [3:0]  activate_A;
   logic        wr_buf_sel;
   logic [1:0]  buf_full;
   logic        busy;
   logic        done;
   logic        cfg_err;

   typedef struct packed {
      logic [11:0] addr;
      logic [3:0]  act;
      logic        sel;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   logic acc_prev = 1'b0;

   mem_write_a_pp #(.N1(4), .MATRIXSIZE_W(16), .ADDR_W(12), .BUF_STRIDE(2048)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_M2(cfg_M2), .cfg_M1dN1(cfg_M1dN1),
      .cfg_transpose(cfg_transpose), .valid_A(valid_A), .ready_A(ready_A),
      .buf_release(buf_release), .wr_addr_A(wr_addr_A), .activate_A(activate_A),
      .wr_buf_sel(wr_buf_sel), .buf_full(buf_full), .busy(busy), .done(done),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Monitor: pops one expected write per active bank enable.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (activate_A != 4'b0000) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr=%0h act=%b expected no write",
                        wr_addr_A, activate_A);
            end else begin
               e = exp_q.pop_front();
               chk("write", {15'b0, wr_addr_A, activate_A, wr_buf_sel}, {15'b0, e});
            end
         end
         if (activate_A != 4'b0000 || acc_prev)
            chk("act_follows_accept", {31'b0, activate_A != 4'b0000}, {31'b0, acc_prev});
         acc_prev = valid_A && ready_A && !rst;
      end
   end

   task automatic push_tile(input int m2, input int m1, input bit tr, input bit sel, input int limit);
      int n = 0;
      exp_t e;
      if (!tr) begin
         for (int ph = 0; ph < m1; ph++)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < m2; c++) begin
                  e.addr = 12'(sel * 2048 + ph * m2 + c);
                  e.act  = 4'(1 << r);
                  e.sel  = sel;
                  if (n < limit) exp_q.push_back(e);
                  n++;
               end
      end else begin
         for (int c = 0; c < m2; c++)
            for (int ph = 0; ph < m1; ph++)
               for (int r = 0; r < 4; r++) begin
                  e.addr = 12'(sel * 2048 + ph * m2 + c);
                  e.act  = 4'(1 << r);
                  e.sel  = sel;
                  if (n < limit) exp_q.push_back(e);
                  n++;
               end
      end
   endtask

   // Entered and left at posedge+1.
   task automatic do_start(input int m2, input int m1, input bit tr);
      cfg_M2        = 16'(m2);
      cfg_M1dN1     = 16'(m1);
      cfg_transpose = tr;
      start         = 1'b1;
      @(posedge clk); #1;
      start         = 1'b0;
   endtask

   task automatic drive_beats(input int n, input bit gaps);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < 2000) begin
         valid_A = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (valid_A && ready_A) got++;
         @(posedge clk); #1;
         cyc++;
      end
      valid_A = 1'b0;
      if (got < n) chk("beats_timeout", 32'(got), 32'(n));
   endtask

   task automatic finish_check(input logic [1:0] want_full);
      @(negedge clk);
      chk("done_hi", {31'b0, done}, 32'd1);
      chk("buf_full_end", {30'b0, buf_full}, {30'b0, want_full});
      chk("ready_drop", {31'b0, ready_A}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_lo", {31'b0, done}, 32'd0);
      chk("busy_lo", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic free_job(input int m2, input int m1, input bit tr, input bit sel,
                           input bit gaps, input logic [1:0] want_full);
      push_tile(m2, m1, tr, sel, m2 * m1 * 4);
      do_start(m2, m1, tr);
      @(negedge clk);
      chk("ready_wait", {31'b0, ready_A}, 32'd0);
      chk("busy_hi", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ready_2cyc", {31'b0, ready_A}, 32'd1);
      @(posedge clk); #1;
      drive_beats(m2 * m1 * 4, gaps);
      finish_check(want_full);
   endtask

   task automatic reset_outputs_check(input string tag);
      chk(tag, {14'b0, wr_addr_A, activate_A, wr_buf_sel, buf_full, busy, done, cfg_err, ready_A},
          32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      reset_outputs_check("reset_state");
      rst = 1'b0;
      @(posedge clk); #1;

      // Row-major into buffer 0, then column-major into buffer 1.
      free_job(3, 2, 1'b0, 1'b0, 1'b0, 2'b01);
      free_job(3, 2, 1'b1, 1'b1, 1'b0, 2'b11);

      // Both buffers full: stall until buffer 0 is released, then gapped input.
      push_tile(3, 2, 1'b0, 1'b0, 24);
      do_start(3, 2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", {31'b0, ready_A}, 32'd0);
         @(posedge clk); #1;
      end
      start = 1'b1;
      cfg_M2 = 16'd7;
      buf_release = 2'b01;
      @(posedge clk); #1;
      start = 1'b0;
      buf_release = 2'b00;
      @(negedge clk);
      chk("release_full", {30'b0, buf_full}, 32'b10);
      chk("release_ready", {31'b0, ready_A}, 32'd1);
      @(posedge clk); #1;
      drive_beats(24, 1'b1);
      finish_check(2'b11);

      // Release buffer 1, then a redundant release of it is ignored.
      buf_release = 2'b10;
      @(posedge clk); #1;
      buf_release = 2'b10;
      @(posedge clk); #1;
      buf_release = 2'b00;
      @(negedge clk);
      chk("release_b1", {30'b0, buf_full}, 32'b01);
      @(posedge clk); #1;

      // Oversized tile: 100*21 = 2100 > 2048.
      do_start(100, 21, 1'b0);
      @(negedge clk);
      chk("cfg_err_hi", {31'b0, cfg_err}, 32'd1);
      chk("err_done_early", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_done", {31'b0, done}, 32'd1);
      chk("cfg_err_lo", {31'b0, cfg_err}, 32'd0);
      chk("err_buf_full", {30'b0, buf_full}, 32'b01);
      @(posedge clk); #1;

      // Empty job: done only.
      do_start(0, 5, 1'b0);
      @(negedge clk);
      chk("zero_err", {31'b0, cfg_err}, 32'd0);
      chk("zero_done_early", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_done", {31'b0, done}, 32'd1);
      chk("zero_buf_full", {30'b0, buf_full}, 32'b01);
      @(posedge clk); #1;

      // Reset during beat 10 of a buffer-1 job.
      push_tile(3, 2, 1'b0, 1'b1, 9);
      do_start(3, 2, 1'b0);
      @(posedge clk); #1;
      drive_beats(9, 1'b0);
      valid_A = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      valid_A = 1'b0;
      @(negedge clk);
      reset_outputs_check("mid_job_reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Fresh job lands in buffer 0 at base 0.
      free_job(2, 1, 1'b1, 1'b0, 1'b0, 2'b01);

      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
